// File: rtl/time_uart_tx.sv
// Serialises the BCD time as "HH:MM:SS\r\n" over an 8N1 UART each time the seconds value changes.
// One message may be queued behind the one in flight; any further trigger sets a sticky overrun flag.
module time_uart_tx #(
    parameter int CLK_HZ = 24000000,
    parameter int BAUD   = 115200,
    parameter int DIV    = (CLK_HZ + BAUD / 2) / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] hour,
    input  logic [7:0] minute,
    input  logic [7:0] second,
    output logic       txd,
    output logic       busy,
    output logic       overrun
);

    localparam int CW = ($clog2(DIV) > 0) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state_q, state_d;
    logic [7:0]     sec_q, sec_d;
    logic [23:0]    snap_q, snap_d;
    logic [3:0]     char_idx_q, char_idx_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [CW-1:0]  baud_cnt_q, baud_cnt_d;
    logic           pending_q, pending_d;
    logic           overrun_q, overrun_d;
    logic           txd_q, txd_d;
    logic           busy_q, busy_d;

    logic           trig;
    logic           baud_done;
    logic [7:0]     cur_char;

    function automatic logic [7:0] digit(input logic [3:0] n);
        return (n <= 4'd9) ? {4'h3, n} : 8'h3F;
    endfunction

    function automatic logic [7:0] char_at(input logic [3:0] idx, input logic [23:0] snap);
        logic [7:0] c;
        case (idx)
            4'd0:    c = digit(snap[23:20]);
            4'd1:    c = digit(snap[19:16]);
            4'd2:    c = 8'h3A;
            4'd3:    c = digit(snap[15:12]);
            4'd4:    c = digit(snap[11:8]);
            4'd5:    c = 8'h3A;
            4'd6:    c = digit(snap[7:4]);
            4'd7:    c = digit(snap[3:0]);
            4'd8:    c = 8'h0D;
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    assign trig      = en & (second != sec_q);
    assign baud_done = (baud_cnt_q == CW'(DIV - 1));
    assign cur_char  = char_at(char_idx_q, snap_q);

    always_comb begin
        state_d    = state_q;
        sec_d      = second;
        snap_d     = snap_q;
        char_idx_d = char_idx_q;
        bit_idx_d  = bit_idx_q;
        baud_cnt_d = baud_done ? '0 : baud_cnt_q + CW'(1);
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        txd_d      = txd_q;

        // txd_d always carries the line level of the state being entered, so txd is glitch-free
        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                txd_d      = 1'b1;
                if (trig || pending_q) begin
                    state_d    = START;
                    pending_d  = 1'b0;
                    snap_d     = {hour, minute, second};
                    char_idx_d = 4'd0;
                    txd_d      = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    txd_d     = cur_char[0];
                end
            end
            DATA: begin
                if (baud_done) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = cur_char[3'(bit_idx_q + 3'd1)];
                    end
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (char_idx_q == 4'd9) begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end else begin
                        state_d    = START;
                        char_idx_d = char_idx_q + 4'd1;
                        txd_d      = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // A trigger seen in IDLE is consumed by the exit above; only in-flight triggers queue
        if (trig && (state_q != IDLE)) begin
            pending_d = 1'b1;
            if (pending_q) begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sec_q      <= 8'h00;
            snap_q     <= 24'h0;
            char_idx_q <= 4'd0;
            bit_idx_q  <= 3'd0;
            baud_cnt_q <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            snap_q     <= snap_d;
            char_idx_q <= char_idx_d;
            bit_idx_q  <= bit_idx_d;
            baud_cnt_q <= baud_cnt_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    assign txd     = txd_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_time_uart_tx.sv
// Self-checking bench for time_uart_tx at DIV=10: a UART receiver task decodes txd and
// compares each byte against an expected-byte queue filled when the seconds value is driven.
module tb_time_uart_tx;

  localparam logic [15:0] CRLF = 16'h0D0A;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] hour;
  logic [7:0] minute;
  logic [7:0] second;
  logic       txd;
  logic       busy;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  h;
    logic [7:0]  m;
    logic [7:0]  s;
    logic [79:0] line;
  } vec_t;

  vec_t vecs[4];

  time_uart_tx #(.DIV(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .hour    (hour),
    .minute  (minute),
    .second  (second),
    .txd     (txd),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic push_line(input logic [79:0] line);
    for (int k = 0; k < 10; k++) exp_q.push_back(line[79-8*k -: 8]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_second(input logic [7:0] s);
    @(posedge clk);
    #1 second = s;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
    end
    if (!done) report_fail("idle_timeout");
  endtask

  task automatic quiet_count(input int cycles, output int active);
    active = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) active++;
    end
  endtask

  // ---------------- UART receiver ----------------
  task automatic rx_byte(output logic [7:0] b, output bit ok);
    ok = 0;
    b  = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) return;
    repeat (4) @(negedge clk);
    check("start_bit", txd, 1'b0);
    for (int j = 0; j < 8; j++) begin
      repeat (10) @(negedge clk);
      b[j] = txd;
    end
    repeat (10) @(negedge clk);
    check("stop_bit", txd, 1'b1);
  endtask

  task automatic rx_msg(input int nbytes);
    logic [7:0] b;
    logic [7:0] e;
    bit ok;
    for (int i = 0; i < nbytes; i++) begin
      rx_byte(b, ok);
      if (!ok) begin
        report_fail($sformatf("rx_timeout byte%0d", i));
        break;
      end
      if (exp_q.size() == 0) begin
        report_fail($sformatf("unexpected_byte 0x%0h", b));
      end else begin
        e = exp_q.pop_front();
        check($sformatf("byte%0d", i), b, e);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int active;
    int busy_cycles;
    int gap;
    int cnt;
    logic [99:0] samples;
    logic [9:0]  line_exp;

    vecs[0] = '{h: 8'h12, m: 8'h34, s: 8'h56, line: {"12:34:56", CRLF}};
    vecs[1] = '{h: 8'h23, m: 8'h59, s: 8'h59, line: {"23:59:59", CRLF}};
    vecs[2] = '{h: 8'h00, m: 8'h7F, s: 8'h00, line: {"00:7?:00", CRLF}};
    vecs[3] = '{h: 8'hA0, m: 8'h05, s: 8'hF9, line: {"?0:05:?9", CRLF}};

    // reset
    rst = 1'b1; en = 1'b1; hour = 8'h12; minute = 8'h34; second = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", txd, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    rst = 1'b0;

    // en=0: seconds changes are ignored
    en = 1'b0;
    active = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 second = 8'h50 + 8'(k);
      quiet_count(4, cnt);
      active += cnt;
    end
    second = 8'h55;
    quiet_count(4, cnt);
    active += cnt;
    en = 1'b1;
    quiet_count(5, cnt);
    active += cnt;
    check("en0_no_activity", active, 0);

    // basic message: latency, bytes and busy width
    start_second(8'h56);
    push_line({"12:34:56", CRLF});
    @(posedge clk);
    #1;
    check("latency_txd", txd, 1'b0);
    check("latency_busy", busy, 1'b1);
    busy_cycles = 0;
    fork
      rx_msg(10);
      begin
        for (int i = 0; i < 3000; i++) begin
          @(negedge clk);
          if (!busy) break;
          busy_cycles++;
        end
      end
    join
    check("busy_cycles", busy_cycles, 1000);
    wait_idle();

    // bit timing of the first character 0x31
    line_exp = 10'b1001100010;
    start_second(8'h57);
    @(posedge clk);
    #1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      samples[i] = txd;
    end
    for (int b = 0; b < 10; b++) begin
      cnt = 0;
      for (int i = 0; i < 10; i++) if (samples[b*10+i] === line_exp[b]) cnt++;
      check($sformatf("bit_timing%0d", b), cnt, 10);
    end
    wait_idle();
    check("overrun_after_single", overrun, 1'b0);

    // table-driven messages, including invalid digits
    for (int v = 0; v < 4; v++) begin
      repeat (2) @(posedge clk);
      hour = vecs[v].h;
      minute = vecs[v].m;
      start_second(vecs[v].s);
      push_line(vecs[v].line);
      rx_msg(10);
      wait_idle();
    end

    // queued trigger: second message follows after one idle cycle with values at its start
    repeat (2) @(posedge clk);
    hour = 8'h12; minute = 8'h34;
    start_second(8'h10);
    push_line({"12:34:10", CRLF});
    @(posedge clk);
    #1;
    gap = 0;
    fork
      rx_msg(20);
      begin
        repeat (300) @(posedge clk);
        #1 second = 8'h11;
        repeat (200) @(posedge clk);
        #1 hour = 8'h14;
        push_line({"14:34:11", CRLF});
      end
      begin
        for (int i = 0; i < 3000; i++) begin
          @(negedge clk);
          if (!busy) break;
        end
        gap = 1;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (busy) break;
          gap++;
        end
      end
    join
    check("queued_gap", gap, 1);
    wait_idle();
    check("overrun_after_queue", overrun, 1'b0);

    // overrun: three changes in one message give exactly one extra message
    repeat (2) @(posedge clk);
    start_second(8'h20);
    push_line({"14:34:20", CRLF});
    @(posedge clk);
    #1;
    fork
      rx_msg(20);
      begin
        repeat (200) @(posedge clk);
        #1 second = 8'h21;
        repeat (200) @(posedge clk);
        #1 second = 8'h22;
        repeat (200) @(posedge clk);
        #1 second = 8'h23;
        push_line({"14:34:23", CRLF});
      end
    join
    wait_idle();
    quiet_count(300, active);
    check("overrun_no_third_msg", active, 0);
    check("overrun_sticky", overrun, 1'b1);

    // reset during DATA of character 4
    start_second(8'h00);
    repeat (450) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midreset_txd", txd, 1'b1);
    check("midreset_busy", busy, 1'b0);
    check("midreset_overrun", overrun, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    quiet_count(300, active);
    check("after_reset_quiet", active, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/time_uart_tx.md
Name: time_uart_tx

Overview:
- Downstream consumer of the clock block's BCD time outputs.
- On every change of the seconds value it transmits one ASCII line "HH:MM:SS\r\n" over an 8N1 UART on UART_TXD.
- Clocked from the 24 MHz system clock; a free-running baud divider sets the bit timing.
- Gives a host PC a once-per-second DCF77-disciplined timestamp.

Parameters:
- CLK_HZ, 24000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- DIV, CLK_HZ/BAUD rounded to nearest (208 at defaults), clocks per bit. Derived value; may be overridden directly by the bench.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  1 = transmission allowed; 0 = new triggers ignored, a message already in flight completes.
- hour  input  8  BCD hour, [7:4] tens, [3:0] units.
- minute  input  8  BCD minute.
- second  input  8  BCD second.
- txd  output  1  UART serial data, idle high.
- busy  output  1  high from the start bit of character 0 through the stop bit of character 9.
- overrun  output  1  sticky; set when a trigger arrives while a trigger is already pending; cleared only by rst.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: txd=1, busy=0, overrun=0, state=IDLE, pending=0, sec_q=8'h00, bit and baud counters 0.

Trigger:
- sec_q <= second every cycle.
- trig = en & (second != sec_q).
- After reset, a non-zero second triggers once. This is accepted behaviour.

Snapshot:
- On leaving IDLE, {hour, minute, second} is latched into a 24-bit snapshot.
- Inputs are not sampled again during the message.

Character map, index 0..9:
- H10 H1 ':' M10 M1 ':' S10 S1 0x0D 0x0A.
- A digit nibble 0..9 maps to 0x30+nibble.
- A nibble 0xA..0xF maps to '?' (0x3F).

Frame:
- Start bit 0, then 8 data bits LSB first, then stop bit 1.
- Each bit lasts exactly DIV clocks, so one character is 10*DIV clocks and one message is 100*DIV clocks.
- Characters follow back-to-back with no idle gap.

FSM:
- IDLE: txd=1. Exits to START when trig=1 or pending=1; the exit clears pending, loads the snapshot, sets char_idx=0 and zeroes the baud counter.
- START: txd=0 for DIV clocks, then go to DATA with bit_idx=0.
- DATA: txd=char[bit_idx] for DIV clocks per bit. After bit 7, go to STOP.
- STOP: txd=1 for DIV clocks. Then, if char_idx<9, increment char_idx and go to START. If char_idx=9, go to IDLE.

Latency:
- The second input changes at edge N; sec_q differs at edge N; the FSM enters START at edge N+1.
- txd is registered and falls at edge N+1.
- busy rises in the same cycle as txd falls.

Simultaneous and boundary events:
- Trigger while busy: pending<=1.
- Trigger while pending is already 1: overrun<=1, and pending stays 1 (only one queued).
- Pending message: starts on the cycle after STOP of character 9 ends. The snapshot is taken at that start, not at trigger time. There is no IDLE dwell beyond one cycle.
- Trigger in the same cycle as IDLE exit caused by pending: consumed by that exit, not queued.
- en=0: trig is masked. An existing pending is still served.
- rst asserted mid-character: txd returns to 1 immediately (asynchronous), and all state clears. The truncated frame is accepted.
- Baud counter: counts 0..DIV-1 within each bit; there is no fractional accumulation.

Test Plan:
- Basic message (DIV=10): hour=8'h12, minute=8'h34, second 8'h55->8'h56, en=1. Required: txd low 1 cycle after the change; decoded bytes 31 32 3A 33 34 3A 35 36 0D 0A; busy high for exactly 1000 cycles.
- Bit timing: every bit is exactly 10 clocks. The first character 0x31 gives the line sequence 0,1,0,0,0,1,1,0,0,1 (start, data LSB first, stop).
- Queued trigger: one second change mid-message. Required: second message starts 1 cycle after the first ends, carrying the values present at that start; overrun=0.
- Overrun: three second changes within one message. Required: exactly one extra message, and overrun=1 until rst.
- Enable and invalid digits: en=0 with second changing produces no activity and txd stays 1. With en=1 and minute=8'h7F, characters 3 and 4 are 0x37 and 0x3F.
- Reset mid-transmission: rst asserted during DATA of character 4. Required: txd=1 and busy=0 asynchronously. After release with second unchanged, no transmission occurs.
